// File: rtl/acc_classifier.sv
// Linear classifier: collects N_BEAT beats of 4 signed int8 features, scores N_CLASS
// classes with 4 MACs/cycle and reports the argmax. Optional per-class bias: ACC_CLASSIFIER_BIAS_EN.
module acc_classifier #(
  parameter int unsigned N_CLASS = 10,
  parameter int unsigned N_BEAT  = 4
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_rm,
  input  logic [15:0] in_rn,
  input  logic        wt_we,
  input  logic [7:0]  wt_addr,
  input  logic [7:0]  wt_data,
`ifdef ACC_CLASSIFIER_BIAS_EN
  input  logic        bias_we,
  input  logic [3:0]  bias_addr,
  input  logic [15:0] bias_data,
`endif
  output logic [3:0]  predict,
  output logic        acc_done,
  output logic        busy,
  output logic        drop_err
);

  localparam int unsigned N_FEAT = 4 * N_BEAT;
  localparam int unsigned N_W    = N_CLASS * N_FEAT;
  localparam int unsigned BW     = (N_BEAT > 1) ? $clog2(N_BEAT) : 1;
  localparam int unsigned FA_W   = $clog2(N_FEAT);
  localparam int unsigned SW     = 24;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMPUTE, S_DONE} state_t;

  state_t                  r_state;
  logic [BW-1:0]           r_beat;
  logic [BW-1:0]           r_grp;
  logic [3:0]              r_cls;
  logic signed [SW-1:0]    r_score;
  logic signed [SW-1:0]    r_max;
  logic [3:0]              r_best;
  logic [3:0]              r_predict;
  logic                    r_acc_done;
  logic                    r_busy;
  logic                    r_drop_err;

  logic signed [7:0]       r_wt   [0:255];
  logic signed [7:0]       r_feat [0:(2**FA_W)-1];

  logic                    w_busy_st;
  logic                    w_idle_st;
  logic [BW-1:0]           w_wr_beat;
  logic signed [7:0]       w_f [4];
  logic signed [7:0]       w_w [4];
  logic signed [15:0]      w_p [4];
  logic signed [SW-1:0]    w_base;
  logic signed [SW-1:0]    w_sum;
  logic                    w_better;
  logic                    w_grp_last;
  logic                    w_cls_last;

  assign w_busy_st  = (r_state == S_COLLECT) || (r_state == S_COMPUTE);
  assign w_idle_st  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_wr_beat  = w_idle_st ? '0 : r_beat;
  assign w_grp_last = (r_grp == BW'(N_BEAT - 1));
  assign w_cls_last = (r_cls == 4'(N_CLASS - 1));

`ifdef ACC_CLASSIFIER_BIAS_EN
  logic signed [15:0] r_bias [0:15];

  always_ff @(posedge clk_i) begin
    if (bias_we && w_idle_st && (32'(bias_addr) < N_CLASS))
      r_bias[bias_addr] <= bias_data;
  end

  assign w_base = (r_grp == '0) ? SW'(r_bias[r_cls]) : r_score;
`else
  assign w_base = (r_grp == '0) ? '0 : r_score;
`endif

  // One beat group of one class per cycle: 4 parallel signed MACs
  always_comb begin
    w_sum = w_base;
    for (int j = 0; j < 4; j++) begin
      w_f[j] = r_feat[FA_W'({r_grp, 2'(j)})];
      w_w[j] = r_wt[8'(32'(r_cls) * N_FEAT + 32'({r_grp, 2'(j)}))];
      w_p[j] = w_f[j] * w_w[j];
      w_sum  = w_sum + SW'(w_p[j]);
    end
    w_better = (r_cls == 4'd0) || (w_sum > r_max);
  end

  // Weight and feature storage: deliberately not reset
  always_ff @(posedge clk_i) begin
    if (wt_we && w_idle_st && (32'(wt_addr) < N_W))
      r_wt[wt_addr] <= wt_data;
    if (in_valid && (w_idle_st || (r_state == S_COLLECT))) begin
      r_feat[FA_W'({w_wr_beat, 2'd0})] <= in_rm[15:8];
      r_feat[FA_W'({w_wr_beat, 2'd1})] <= in_rm[7:0];
      r_feat[FA_W'({w_wr_beat, 2'd2})] <= in_rn[15:8];
      r_feat[FA_W'({w_wr_beat, 2'd3})] <= in_rn[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_grp      <= '0;
      r_cls      <= '0;
      r_score    <= '0;
      r_max      <= '0;
      r_best     <= '0;
      r_predict  <= '0;
      r_acc_done <= 1'b0;
      r_busy     <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
`ifdef ACC_CLASSIFIER_BIAS_EN
      if ((wt_we || bias_we) && w_busy_st) r_drop_err <= 1'b1;
`else
      if (wt_we && w_busy_st) r_drop_err <= 1'b1;
`endif
      if (in_valid && (r_state == S_COMPUTE)) r_drop_err <= 1'b1;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (in_valid) begin
            r_acc_done <= 1'b0;
            r_busy     <= 1'b1;
            r_beat     <= BW'(1);
            r_cls      <= '0;
            r_grp      <= '0;
            r_state    <= (N_BEAT == 1) ? S_COMPUTE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (in_valid) begin
            r_beat <= BW'(r_beat + 1'b1);
            if (r_beat == BW'(N_BEAT - 1)) r_state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (w_grp_last) begin
            r_grp <= '0;
            if (w_better) begin
              r_max  <= w_sum;
              r_best <= r_cls;
            end
            // Final class: the argmax resolves on the same edge as its last MAC
            if (w_cls_last) begin
              r_predict  <= w_better ? r_cls : r_best;
              r_acc_done <= 1'b1;
              r_busy     <= 1'b0;
              r_cls      <= '0;
              r_state    <= S_DONE;
            end else begin
              r_cls <= 4'(r_cls + 1'b1);
            end
          end else begin
            r_grp   <= BW'(r_grp + 1'b1);
            r_score <= w_sum;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign predict  = r_predict;
  assign acc_done = r_acc_done;
  assign busy     = r_busy;
  assign drop_err = r_drop_err;

endmodule

// File: tb/tb_acc_classifier.sv
// Self-checking bench for acc_classifier: vector table plus scoreboard of expected predictions.
module tb_acc_classifier;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_rm;
  logic [15:0] in_rn;
  logic        wt_we;
  logic [7:0]  wt_addr;
  logic [7:0]  wt_data;
`ifdef ACC_CLASSIFIER_BIAS_EN
  logic        bias_we;
  logic [3:0]  bias_addr;
  logic [15:0] bias_data;
`endif
  logic [3:0]  predict;
  logic        acc_done;
  logic        busy;
  logic        drop_err;

  acc_classifier dut (
    .clk_i    (clk_i),
    .rst      (rst),
    .in_valid (in_valid),
    .in_rm    (in_rm),
    .in_rn    (in_rn),
    .wt_we    (wt_we),
    .wt_addr  (wt_addr),
    .wt_data  (wt_data),
`ifdef ACC_CLASSIFIER_BIAS_EN
    .bias_we  (bias_we),
    .bias_addr(bias_addr),
    .bias_data(bias_data),
`endif
    .predict  (predict),
    .acc_done (acc_done),
    .busy     (busy),
    .drop_err (drop_err)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int  cls;
    byte wv;
    byte ov;
    byte fv;
    int  exp;
  } vec_t;

  vec_t vt[8];
  byte  wm[160];
  int   bm[10];
  byte  feat[16];
  int   exp_q[$];
  int   lb;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int model_predict();
    int best = 0;
    int bs   = 0;
    for (int c = 0; c < 10; c++) begin
      int s = bm[c];
      for (int f = 0; f < 16; f++) s += int'(wm[c*16+f]) * int'(feat[f]);
      if (c == 0 || s > bs) begin
        bs   = s;
        best = c;
      end
    end
    return best;
  endfunction

  task automatic write_wt(input int a, input int d);
    wt_we   = 1'b1;
    wt_addr = 8'(a);
    wt_data = 8'(d);
    step();
    wt_we   = 1'b0;
  endtask

  task automatic load_pat(input int cls, input byte wv, input byte ov);
    for (int a = 0; a < 160; a++) begin
      wm[a] = (a / 16 == cls) ? wv : ov;
      write_wt(a, int'(wm[a]));
    end
  endtask

  task automatic load_rand();
    for (int a = 0; a < 160; a++) begin
      wm[a] = byte'($urandom_range(0, 255));
      write_wt(a, int'(wm[a]));
    end
  endtask

  task automatic set_feat(input byte v);
    for (int f = 0; f < 16; f++) feat[f] = v;
  endtask

  // Pushes the expected prediction (model when exp < 0), then drives 4 beats
  task automatic send_sample(input int exp, input bit do_w, input int wa, input int wd, input int gap);
    int e;
    if (do_w) wm[wa] = byte'(wd);
    e = (exp < 0) ? model_predict() : exp;
    exp_q.push_back(e);
    for (int b = 0; b < 4; b++) begin
      in_rm    = {feat[4*b], feat[4*b+1]};
      in_rn    = {feat[4*b+2], feat[4*b+3]};
      in_valid = 1'b1;
      if (b == 0 && do_w) begin
        wt_we   = 1'b1;
        wt_addr = 8'(wa);
        wt_data = 8'(wd);
      end
      step();
      in_valid = 1'b0;
      wt_we    = 1'b0;
      if (b == 3) lb = cyc;
      else repeat (gap) step();
    end
  endtask

  task automatic wait_done();
    int  exp;
    bit  seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (acc_done) seen = 1'b1;
      else step();
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL acc_done timeout: got no acc_done within 200 cycles, expected predict %0d", exp);
    end else begin
      check("latency", cyc - lb, 40);
      check("predict", int'(predict), exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    vt[0] = '{cls: 7, wv: 8'sd1,    ov: 8'sd0,    fv: 8'sd1,    exp: 7};
    vt[1] = '{cls: 0, wv: 8'sd0,    ov: 8'sd0,    fv: 8'sd5,    exp: 0};
    vt[2] = '{cls: 3, wv: -8'sd1,   ov: 8'sd0,    fv: -8'sd2,   exp: 3};
    vt[3] = '{cls: 9, wv: 8'sd1,    ov: 8'sd0,    fv: -8'sd1,   exp: 0};
    vt[4] = '{cls: 9, wv: -8'sd1,   ov: 8'sd0,    fv: -8'sd1,   exp: 9};
    vt[5] = '{cls: 0, wv: 8'sd2,    ov: 8'sd1,    fv: 8'sd3,    exp: 0};
    vt[6] = '{cls: 5, wv: 8'sd127,  ov: -8'sd128, fv: -8'sd128, exp: 0};
    vt[7] = '{cls: 2, wv: 8'sd1,    ov: 8'sd0,    fv: 8'sd127,  exp: 2};
    for (int c = 0; c < 10; c++) bm[c] = 0;

    rst = 1'b1; in_valid = 1'b0; in_rm = '0; in_rn = '0;
    wt_we = 1'b0; wt_addr = '0; wt_data = '0;
`ifdef ACC_CLASSIFIER_BIAS_EN
    bias_we = 1'b0; bias_addr = '0; bias_data = '0;
`endif
    step(); step();
    rst = 1'b0;
    check("reset predict", int'(predict), 0);
    check("reset acc_done", int'(acc_done), 0);
    check("reset busy", int'(busy), 0);
    check("reset drop_err", int'(drop_err), 0);

`ifdef ACC_CLASSIFIER_BIAS_EN
    for (int c = 0; c < 10; c++) begin
      bias_we = 1'b1; bias_addr = 4'(c); bias_data = '0;
      step();
    end
    bias_we = 1'b0;
`endif

    // Out-of-range weight writes are silent
    write_wt(160, 8'h55);
    write_wt(255, 8'h7f);
    check("oob write drop_err", int'(drop_err), 0);

    for (int i = 0; i < 8; i++) begin
      load_pat(vt[i].cls, vt[i].wv, vt[i].ov);
      set_feat(vt[i].fv);
      send_sample(vt[i].exp, 1'b0, 0, 0, 0);
      wait_done();
    end

    // DONE holds its result
    repeat (5) step();
    check("done hold acc_done", int'(acc_done), 1);
    check("done hold predict", int'(predict), 2);

    // Beat arriving mid-compute is dropped
    load_pat(7, 8'sd1, 8'sd0);
    set_feat(8'sd1);
    send_sample(7, 1'b0, 0, 0, 0);
    repeat (9) step();
    in_rm = 16'h8080; in_rn = 16'h8080; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done();
    check("drop_err after beat in compute", int'(drop_err), 1);

    // Weight write mid-compute is ignored
    do_reset();
    check("drop_err cleared by rst", int'(drop_err), 0);
    send_sample(7, 1'b0, 0, 0, 0);
    repeat (5) step();
    write_wt(7*16, 8'h80);
    wait_done();
    check("drop_err after wt_we in compute", int'(drop_err), 1);
    send_sample(7, 1'b0, 0, 0, 1);
    wait_done();

    // Weight write together with beat 0 from DONE: sample sees the new weight
    send_sample(2, 1'b1, 2*16, 100, 0);
    check("acc_done cleared on new sample", int'(acc_done), 0);
    check("busy while collecting", int'(busy), 1);
    wait_done();

    // Reset mid-compute aborts, weights survive
    load_pat(7, 8'sd1, 8'sd0);
    send_sample(7, 1'b0, 0, 0, 0);
    repeat (19) step();
    check("busy in compute", int'(busy), 1);
    do_reset();
    void'(exp_q.pop_front());
    check("rst acc_done", int'(acc_done), 0);
    check("rst predict", int'(predict), 0);
    check("rst busy", int'(busy), 0);
    repeat (60) step();
    check("no done after abort", int'(acc_done), 0);
    send_sample(7, 1'b0, 0, 0, 0);
    wait_done();

    // Random weights and features with gaps between beats
    for (int r = 0; r < 3; r++) begin
      load_rand();
      for (int f = 0; f < 16; f++) feat[f] = byte'($urandom_range(0, 255));
      send_sample(-1, 1'b0, 0, 0, 3);
      wait_done();
    end

    // Bias on class 5 (no effect when the bias feature is absent)
    load_pat(0, 8'sd0, 8'sd0);
    set_feat(8'sd3);
`ifdef ACC_CLASSIFIER_BIAS_EN
    bias_we = 1'b1; bias_addr = 4'd5; bias_data = 16'd100;
    step();
    bias_we = 1'b0;
    bm[5] = 100;
    send_sample(5, 1'b0, 0, 0, 0);
`else
    send_sample(0, 1'b0, 0, 0, 0);
`endif
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_classifier.md
ACC_CLASSIFIER -- requirements
Module: acc_classifier

Interface
REQ-001 Parameter: N_CLASS, default 10, number of classes scored (legal 2..16).
REQ-002 Parameter: N_BEAT, default 4, number of input beats per sample; each beat carries 4 features, so there are 4*N_BEAT features.
REQ-003 Port: clk_i, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 Port: rst, input, 1 bit, synchronous active-high reset.
REQ-005 Port: in_valid, input, 1 bit, a feature beat is present this cycle.
REQ-006 Port: in_rm, input, 16 bits, CPU Rm word: [15:8] is feature 4b+0 and [7:0] is feature 4b+1, both signed 8-bit.
REQ-007 Port: in_rn, input, 16 bits, CPU Rn word: [15:8] is feature 4b+2 and [7:0] is feature 4b+3, both signed 8-bit.
REQ-008 Port: wt_we, input, 1 bit, weight write strobe.
REQ-009 Port: wt_addr, input, 8 bits, weight address = class*(4*N_BEAT) + feature index.
REQ-010 Port: wt_data, input, 8 bits, signed weight.
REQ-011 Port: predict, output, 4 bits, winning class index.
REQ-012 Port: acc_done, output, 1 bit, predict valid (polled by the CPU).
REQ-013 Port: busy, output, 1 bit, high in COLLECT or COMPUTE.
REQ-014 Port: drop_err, output, 1 bit, sticky flag: a beat was dropped.

Function
REQ-015 The FSM SHALL have four states: IDLE, COLLECT, COMPUTE, DONE.
REQ-016 IDLE/DONE + in_valid: store beat 0, beat_cnt <= 1, enter COLLECT, acc_done <= 0 on the same edge; if N_BEAT=1, enter COMPUTE directly.
REQ-017 COLLECT + in_valid: store beat at beat_cnt; on the last beat (N_BEAT-1) enter COMPUTE; cycles without in_valid hold state with no timeout.
REQ-018 COMPUTE SHALL perform 4 signed 8x8 MACs per cycle (one beat group per cycle, for one class), taking N_CLASS*N_BEAT cycles in total, with the class index outer and the group index inner.
REQ-019 Class score is a signed 24-bit sum; products are sign-extended; no saturation.
REQ-020 Argmax: class 0 initialises the running max; a later class replaces it only when its score is strictly greater, so ties resolve to the lowest index.
REQ-021 Latency: acc_done and predict SHALL be valid exactly N_CLASS*N_BEAT edges after the edge that samples the last beat (40 edges at the defaults).
REQ-022 DONE SHALL hold predict and acc_done steady until the next in_valid, or until rst.
REQ-023 in_valid during COMPUTE: the beat is discarded, drop_err <= 1, and the computation is unaffected.
REQ-024 wt_we is honoured only in IDLE or DONE; in COLLECT or COMPUTE it is ignored and drop_err <= 1.
REQ-025 wt_addr >= N_CLASS*4*N_BEAT: the write is ignored silently.
REQ-026 Simultaneous in_valid and wt_we in IDLE/DONE: both are performed; the new sample uses the new weight.

Reset
REQ-027 When rst is sampled high: state <= IDLE, beat_cnt, class counter, group counter and score <= 0, predict <= 0, acc_done <= 0, drop_err <= 0.
REQ-028 rst in any state, including mid-COMPUTE, aborts the current sample; the next sample after rst SHALL compute correctly.
REQ-029 Weight storage (and bias storage, if present) SHALL be unaffected by rst.

Configuration
REQ-030 Macro ACC_CLASSIFIER_BIAS_EN defined: add ports bias_we (1 bit), bias_addr (4 bits) and bias_data (16-bit signed); each class score starts at its sign-extended bias, with write rules as in REQ-024 and REQ-025.
REQ-031 Macro ACC_CLASSIFIER_BIAS_EN undefined: no bias ports exist, and every class score starts at 0.

Verification
REQ-032 Load all weights 0 except class 7 = 1; send 4 beats with every feature 8'h01 -> acc_done high 40 edges after the last beat, predict=7.
REQ-033 Load all weights 0; send any sample -> predict=0 (tie resolves to the lowest index).
REQ-034 Load class 3 weights 8'hFF and all others 0; send every feature 8'hFE -> class 3 score +32, predict=3.
REQ-035 Pulse in_valid at COMPUTE cycle 10 -> drop_err=1, predict still the expected value, acc_done at the same edge.
REQ-036 Assert rst at COMPUTE cycle 20 -> the next edge shows acc_done=0, predict=0, busy=0; repeating REQ-032 then gives predict=7.
REQ-037 With ACC_CLASSIFIER_BIAS_EN defined: all weights 0, bias[5]=100 -> predict=5; without the macro the same stimulus gives predict=0.
